// File: rtl/canvas_write_scheduler_if.sv
// Request/write bus between the tool engines, the scheduler and the canvas BRAM port.
// Every requester field is a flat NUM_REQ-wide concatenation, with lane i in slice i.
interface canvas_write_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 12
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_lock;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*COLOR_W-1:0] req_color;
  logic                       clear_start;
  logic [COLOR_W-1:0]         clear_color;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [COLOR_W-1:0]         wr_data;
  logic [IW-1:0]              grant_id;
  logic                       busy;
  logic                       clear_done;

  modport slave (
    input  req_valid, req_lock, req_addr, req_color, clear_start, clear_color,
    output req_ready, wr_en, wr_addr, wr_data, grant_id, busy, clear_done
  );

  modport master (
    output req_valid, req_lock, req_addr, req_color, clear_start, clear_color,
    input  req_ready, wr_en, wr_addr, wr_data, grant_id, busy, clear_done
  );
endinterface

// File: rtl/canvas_write_scheduler.sv
// Round-robin arbiter for the single canvas write port, with stroke locking and a
// top-priority full-canvas clear sweep.
module canvas_write_scheduler #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = 17,
  parameter int COLOR_W      = 12,
  parameter int CANVAS_DEPTH = 76800
) (
  input  logic                    clk,
  input  logic                    rst_n,
  canvas_write_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (CANVAS_DEPTH > 1) ? $clog2(CANVAS_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOCKED, CLEAR} state_t;

  state_t                           r_state, w_state_nxt;
  logic [IW-1:0]                    r_rr_ptr, r_owner, r_grant_id;
  logic [IW-1:0]                    w_win, w_idx, w_sel, w_sel_inc;
  logic                             w_found, w_acc, w_last;
  logic                             r_clear_pend, r_clear_done, r_wr_en;
  logic [CW-1:0]                    r_clear_cnt;
  logic [COLOR_W-1:0]               r_clr_color, r_wr_data;
  logic [ADDR_W-1:0]                r_wr_addr;
  logic [NUM_REQ-1:0]               w_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   w_addr;
  logic [NUM_REQ-1:0][COLOR_W-1:0]  w_color;

  assign w_addr  = bus.req_addr;
  assign w_color = bus.req_color;

  // First valid lane at or after rr_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_sel     = (r_state == LOCKED) ? r_owner : w_win;
  assign w_sel_inc = (w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + IW'(1);
  assign w_acc     = |(bus.req_valid & w_ready);
  assign w_last    = (r_state == CLEAR) && (r_clear_cnt == CW'(CANVAS_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_clear_pend)                          w_state_nxt = CLEAR;
        else if (w_acc && bus.req_lock[w_win])     w_state_nxt = LOCKED;
      end
      // Released either by a final unlocked beat or by the owner going idle unlocked.
      LOCKED: if (!bus.req_lock[r_owner])          w_state_nxt = IDLE;
      CLEAR:  if (w_last)                          w_state_nxt = IDLE;
      default:                                     w_state_nxt = IDLE;
    endcase
  end

  // Ready never looks at ready, so there is no combinational loop through the requesters.
  always_comb begin
    w_ready = '0;
    case (r_state)
      IDLE:    if (!r_clear_pend && w_found) w_ready[w_win] = 1'b1;
      LOCKED:  w_ready[r_owner] = bus.req_valid[r_owner];
      default: w_ready = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_grant_id   <= '0;
      r_clear_done <= 1'b0;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_clear_pend <= 1'b0;
      r_clear_cnt  <= '0;
      r_clr_color  <= '0;
    end else begin
      r_wr_en      <= w_acc || (r_state == CLEAR);
      r_clear_done <= w_last;
      if (w_acc) begin
        r_wr_addr  <= w_addr[w_sel];
        r_wr_data  <= w_color[w_sel];
        r_grant_id <= w_sel;
      end else if (r_state == CLEAR) begin
        r_wr_addr  <= ADDR_W'(r_clear_cnt);
        r_wr_data  <= r_clr_color;
        r_grant_id <= '0;
      end
      if ((r_state == IDLE && w_acc && !bus.req_lock[w_sel]) ||
          (r_state == LOCKED && !bus.req_lock[r_owner]))
        r_rr_ptr <= w_sel_inc;
      if (r_state == IDLE && w_acc && bus.req_lock[w_win])
        r_owner <= w_win;
      // A clear request arriving during a sweep is absorbed by the sweep in progress.
      if (w_last)                                    r_clear_pend <= 1'b0;
      else if (bus.clear_start && r_state != CLEAR)  r_clear_pend <= 1'b1;
      if (r_state == IDLE && r_clear_pend) begin
        r_clear_cnt <= '0;
        r_clr_color <= bus.clear_color;
      end else if (r_state == CLEAR) begin
        r_clear_cnt <= r_clear_cnt + CW'(1);
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.grant_id   = r_grant_id;
  assign bus.clear_done = r_clear_done;
  assign bus.busy       = r_clear_pend | (r_state == CLEAR);
endmodule

// File: tb/tb_canvas_write_scheduler.sv
// Directed bench: arbitration/lock vectors from a table, hand sequences for the clear sweeps
// and for reset in the middle of a sweep.
module tb_canvas_write_scheduler;
  localparam int NR = 3, AW = 17, CLW = 12, DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  canvas_write_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .COLOR_W(CLW)) bus ();

  canvas_write_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .COLOR_W(CLW), .CANVAS_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  v, l;
    logic        cs;
    logic [2:0]  rdy;
    logic        we;
    int          a;
    logic [11:0] d;
    int          g;
    logic        bsy, dn;
  } vec_t;

  vec_t tbl[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [2:0] v, l, logic cs, logic [2:0] rdy, logic we,
                              int a, logic [11:0] d, int g, logic bsy, dn);
    vec_t t;
    t.v = v; t.l = l; t.cs = cs; t.rdy = rdy; t.we = we;
    t.a = a; t.d = d; t.g = g; t.bsy = bsy; t.dn = dn;
    return t;
  endfunction

  // Drive one cycle of inputs, check ready before the edge and the write after it.
  task automatic step(input vec_t t, input string nm);
    bus.req_valid   = t.v;
    bus.req_lock    = t.l;
    bus.clear_start = t.cs;
    #1;
    chk({nm, ".ready"}, 32'(bus.req_ready), 32'(t.rdy));
    @(posedge clk);
    #1;
    bus.clear_start = 1'b0;
    chk({nm, ".wr_en"}, 32'(bus.wr_en), 32'(t.we));
    if (t.we) begin
      chk({nm, ".wr_addr"}, 32'(bus.wr_addr), t.a);
      chk({nm, ".wr_data"}, 32'(bus.wr_data), 32'(t.d));
      chk({nm, ".grant_id"}, 32'(bus.grant_id), t.g);
    end
    chk({nm, ".busy"}, 32'(bus.busy), 32'(t.bsy));
    chk({nm, ".clear_done"}, 32'(bus.clear_done), 32'(t.dn));
  endtask

  // n clear writes starting at address 0; second clear_start injected at index cs_at.
  task automatic sweep(input int n, input int cs_at, input logic [2:0] v, input string nm);
    for (int k = 0; k < n; k++)
      step(mk(v, 3'b000, k == cs_at, 3'b000, 1'b1, k, 12'hFFF, 0,
              k != DEPTH - 1, k == DEPTH - 1), $sformatf("%s[%0d]", nm, k));
  endtask

  task automatic all_zero(input string nm);
    chk({nm, ".wr_en"}, 32'(bus.wr_en), 0);
    chk({nm, ".wr_addr"}, 32'(bus.wr_addr), 0);
    chk({nm, ".wr_data"}, 32'(bus.wr_data), 0);
    chk({nm, ".grant_id"}, 32'(bus.grant_id), 0);
    chk({nm, ".busy"}, 32'(bus.busy), 0);
    chk({nm, ".clear_done"}, 32'(bus.clear_done), 0);
    chk({nm, ".ready"}, 32'(bus.req_ready), 0);
  endtask

  initial begin
    bus.req_valid   = '0;
    bus.req_lock    = '0;
    bus.clear_start = 1'b0;
    bus.clear_color = 12'hFFF;
    bus.req_addr    = {17'd30, 17'd20, 17'd10};
    bus.req_color   = {12'h333, 12'h222, 12'h111};

    // Round robin, all valid, no lock.
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b001, 1, 10, 12'h111, 0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b010, 1, 20, 12'h222, 1, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b100, 1, 30, 12'h333, 2, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b001, 1, 10, 12'h111, 0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b010, 1, 20, 12'h222, 1, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b100, 1, 30, 12'h333, 2, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 0, 3'b000, 0, 0, 12'h000, 0, 0, 0));
    // Requester 1 locked 4-beat stroke, then grant moves on to 2.
    tbl.push_back(mk(3'b010, 3'b010, 0, 3'b010, 1, 20, 12'h222, 1, 0, 0));
    tbl.push_back(mk(3'b111, 3'b010, 0, 3'b010, 1, 20, 12'h222, 1, 0, 0));
    tbl.push_back(mk(3'b111, 3'b010, 0, 3'b010, 1, 20, 12'h222, 1, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b010, 1, 20, 12'h222, 1, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b100, 1, 30, 12'h333, 2, 0, 0));
    // Owner 0 drops valid while still locked: nothing written, others blocked.
    tbl.push_back(mk(3'b001, 3'b001, 0, 3'b001, 1, 10, 12'h111, 0, 0, 0));
    tbl.push_back(mk(3'b110, 3'b001, 0, 3'b000, 0, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(3'b110, 3'b001, 0, 3'b000, 0, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b001, 1, 10, 12'h111, 0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 0, 3'b000, 0, 0, 12'h000, 0, 0, 0));
    // Lock released without a write, pointer moves past the owner.
    tbl.push_back(mk(3'b001, 3'b001, 0, 3'b001, 1, 10, 12'h111, 0, 0, 0));
    tbl.push_back(mk(3'b110, 3'b000, 0, 3'b000, 0, 0, 12'h000, 0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 0, 3'b010, 1, 20, 12'h222, 1, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    all_zero("in_reset");
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      all_zero($sformatf("idle[%0d]", c));
    end

    foreach (tbl[i]) step(tbl[i], $sformatf("vec[%0d]", i));

    // Clear requested while requester 0 streams; its beat completes first.
    step(mk(3'b001, 3'b000, 1, 3'b001, 1, 10, 12'h111, 0, 1, 0), "clr_acc");
    step(mk(3'b001, 3'b000, 0, 3'b000, 0, 0, 12'h000, 0, 1, 0), "clr_arm");
    sweep(DEPTH, -1, 3'b001, "sweep1");
    step(mk(3'b001, 3'b000, 0, 3'b001, 1, 10, 12'h111, 0, 0, 0), "resume");

    // Clear deferred behind a lock; second clear_start mid-sweep is ignored.
    step(mk(3'b010, 3'b010, 0, 3'b010, 1, 20, 12'h222, 1, 0, 0), "lk_start");
    step(mk(3'b010, 3'b010, 1, 3'b010, 1, 20, 12'h222, 1, 1, 0), "lk_clr");
    step(mk(3'b010, 3'b000, 0, 3'b010, 1, 20, 12'h222, 1, 1, 0), "lk_end");
    step(mk(3'b010, 3'b000, 0, 3'b000, 0, 0, 12'h000, 0, 1, 0), "lk_arm");
    sweep(DEPTH, 5, 3'b010, "sweep2");
    step(mk(3'b000, 3'b000, 0, 3'b000, 0, 0, 12'h000, 0, 0, 0), "no_restart0");
    step(mk(3'b000, 3'b000, 0, 3'b000, 0, 0, 12'h000, 0, 0, 0), "no_restart1");

    // Reset right after clear write 7 becomes visible.
    step(mk(3'b000, 3'b000, 1, 3'b000, 0, 0, 12'h000, 0, 1, 0), "rs_req");
    step(mk(3'b000, 3'b000, 0, 3'b000, 0, 0, 12'h000, 0, 1, 0), "rs_arm");
    sweep(8, -1, 3'b000, "sweep3");
    rst_n = 1'b0;
    #1;
    chk("rst_mid.wr_en", 32'(bus.wr_en), 0);
    chk("rst_mid.busy", 32'(bus.busy), 0);
    chk("rst_mid.clear_done", 32'(bus.clear_done), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++)
      step(mk(3'b000, 3'b000, 0, 3'b000, 0, 0, 12'h000, 0, 0, 0), $sformatf("post_rst[%0d]", c));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
